laser_pixel_sink: RTL and testbench

- Consumer end of the laser draw stream.
- Accepts per-pixel draw requests (x offset, colour, write strobe) relative to a latched base coordinate and clips them to the 160x120 screen.
- Buffers requests in a small FIFO and drains them one pixel per accepted cycle into the VGA adapter's x/y/colour/plot interface, honouring adapter back-pressure.
- Sits between the laser draw FSM and the VGA adapter.

---
 rtl/laser_pkg.sv | 43 ++++
 rtl/pixel_fifo.sv | 79 +++++++
 rtl/laser_pixel_sink.sv | 188 ++++++++++++++++++
 tb/tb_laser_pixel_sink.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/laser_pkg.sv
// -----------------------------------------------------------------------------
// laser_pkg
// Shared definitions for the laser draw stream consumer (laser_pixel_sink).
//   SCREEN_W / SCREEN_H : visible screen size in pixels (160 x 120)
//   pixel_t             : one queued pixel {x, y, colour}
//   out_state_t         : output register state (EMPTY / FULL)
//   COL_*               : commonly used 3-bit RGB colours
//   pixel_clipped()     : off-screen test for an absolute coordinate
//   sat_inc16()         : saturating 16-bit increment for statistics
// -----------------------------------------------------------------------------
package laser_pkg;

   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;

   localparam logic [2:0] COL_BLACK   = 3'b000;
   localparam logic [2:0] COL_RED     = 3'b100;
   localparam logic [2:0] COL_MAGENTA = 3'b101;

   typedef struct packed {
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] colour;
   } pixel_t;

   typedef enum logic {
      OUT_EMPTY = 1'b0,
      OUT_FULL  = 1'b1
   } out_state_t;

   // Column is tested at 9 bits so base_x + add_x never wraps back on screen.
   function automatic logic pixel_clipped(input logic [8:0] abs_x,
                                          input logic [7:0] abs_y,
                                          input logic [8:0] lim_x,
                                          input logic [7:0] lim_y);
      return (abs_x >= lim_x) || (abs_y >= lim_y);
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] value);
      return (value == 16'hFFFF) ? value : (value + 16'd1);
   endfunction

endpackage

// File: rtl/pixel_fifo.sv
// -----------------------------------------------------------------------------
// pixel_fifo
// Small synchronous FIFO of pixel_t entries with first-word fall-through read
// data (rd_data always shows the head entry).
// Parameters:
//   DEPTH   : number of entries, power of two, 2..16
// Ports:
//   clk, reset : clock, asynchronous active-high reset (pointers/count only)
//   push       : write wr_data at the tail (ignored when full)
//   pop        : drop the head entry (ignored when empty)
//   wr_data    : pixel to write
//   rd_data    : current head pixel, valid when !empty
//   full/empty : occupancy flags derived from the registered count
//   count      : number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module pixel_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  laser_pkg::pixel_t        wr_data,
   output laser_pkg::pixel_t        rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   import laser_pkg::*;

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_ONE_C = CW'(1);
   localparam logic [AW-1:0] PTR_ONE_C = AW'(1);

   pixel_t          mem_r [DEPTH];
   logic [AW-1:0]   wr_ptr_r;
   logic [AW-1:0]   rd_ptr_r;
   logic [CW-1:0]   count_r;
   logic            push_s;
   logic            pop_s;

   assign full    = (count_r == DEPTH_C);
   assign empty   = (count_r == {CW{1'b0}});
   assign count   = count_r;
   assign push_s  = push && !full;
   assign pop_s   = pop && !empty;
   assign rd_data = mem_r[rd_ptr_r];

   // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_ONE_C;
            2'b01:   count_r <= count_r - CNT_ONE_C;
            default: count_r <= count_r;
         endcase
      end
   end

   // Entry storage; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= wr_data;
      end
   end

endmodule

// File: rtl/laser_pixel_sink.sv
// -----------------------------------------------------------------------------
// laser_pixel_sink
// Consumer end of the laser draw stream. Each accepted request is turned into
// an absolute coordinate (base + x offset), clipped to the screen, queued in a
// pixel_fifo and drained one pixel per cycle into the VGA adapter interface
// under adapter back-pressure.
// Parameters:
//   DEPTH    : FIFO entries (power of two, 2..16)
//   SCREEN_W : columns; abs_x >= SCREEN_W is clipped
//   SCREEN_H : rows;    abs_y >= SCREEN_H is clipped
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   base_x, base_y        : laser origin, sampled with each accepted request
//   add_x, colour_in      : column offset and colour of the requested pixel
//   write_en / in_ready   : request strobe / FIFO not full
//   x, y, colour, plot    : VGA adapter pixel interface (registered)
//   vga_ready             : adapter takes the pixel when plot && vga_ready
//   overflow              : sticky, a request arrived while in_ready was low
// Optional (macro LASER_SINK_STATS_EN):
//   plotted_cnt, clipped_cnt : saturating 16-bit event counters
// -----------------------------------------------------------------------------
module laser_pixel_sink #(
   parameter int DEPTH    = 4,
   parameter int SCREEN_W = laser_pkg::SCREEN_W,
   parameter int SCREEN_H = laser_pkg::SCREEN_H
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  base_x,
   input  logic [6:0]  base_y,
   input  logic [2:0]  add_x,
   input  logic [2:0]  colour_in,
   input  logic        write_en,
   output logic        in_ready,
   output logic [7:0]  x,
   output logic [6:0]  y,
   output logic [2:0]  colour,
   output logic        plot,
   input  logic        vga_ready,
   output logic        overflow
`ifdef LASER_SINK_STATS_EN
   ,
   output logic [15:0] plotted_cnt,
   output logic [15:0] clipped_cnt
`endif
);
   import laser_pkg::*;

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [8:0]    LIM_X_C = 9'(SCREEN_W);
   localparam logic [7:0]    LIM_Y_C = 8'(SCREEN_H);

   out_state_t      state_r;
   out_state_t      state_n_s;
   logic [8:0]      abs_x_s;
   logic            clipped_s;
   logic            accept_s;
   logic            push_s;
   logic            pop_s;
   pixel_t          push_px_s;
   pixel_t          head_px_s;
   logic            fifo_full_s;
   logic            fifo_empty_s;
   logic [CW-1:0]   fifo_count_s;
   logic [7:0]      x_r;
   logic [6:0]      y_r;
   logic [2:0]      colour_r;
   logic            overflow_r;

   // Readiness comes from the registered count only, so it is the pre-pop view.
   assign in_ready  = (fifo_count_s != DEPTH_C);
   assign accept_s  = write_en && in_ready;
   assign abs_x_s   = {1'b0, base_x} + {6'b000000, add_x};
   assign clipped_s = pixel_clipped(abs_x_s, {1'b0, base_y}, LIM_X_C, LIM_Y_C);
   assign push_s    = accept_s && !clipped_s;
   assign push_px_s = '{x: abs_x_s[7:0], y: base_y, colour: colour_in};

   pixel_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (push_s),
      .pop     (pop_s),
      .wr_data (push_px_s),
      .rd_data (head_px_s),
      .full    (fifo_full_s),
      .empty   (fifo_empty_s),
      .count   (fifo_count_s)
   );

   // Output register state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= OUT_EMPTY;
      end else begin
         state_r <= state_n_s;
      end
   end

   // Next state and pop decision; a consumed pixel is replaced in the same cycle.
   always_comb begin
      state_n_s = state_r;
      pop_s     = 1'b0;
      case (state_r)
         OUT_EMPTY: begin
            if (!fifo_empty_s) begin
               pop_s     = 1'b1;
               state_n_s = OUT_FULL;
            end else begin
               state_n_s = OUT_EMPTY;
            end
         end
         OUT_FULL: begin
            if (vga_ready) begin
               if (!fifo_empty_s) begin
                  pop_s     = 1'b1;
                  state_n_s = OUT_FULL;
               end else begin
                  state_n_s = OUT_EMPTY;
               end
            end else begin
               state_n_s = OUT_FULL;
            end
         end
         default: begin
            state_n_s = OUT_EMPTY;
         end
      endcase
   end

   // Pixel output register, loaded only when the head entry is popped.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x_r      <= 8'd0;
         y_r      <= 7'd0;
         colour_r <= COL_BLACK;
      end else if (pop_s) begin
         x_r      <= head_px_s.x;
         y_r      <= head_px_s.y;
         colour_r <= head_px_s.colour;
      end else begin
         x_r      <= x_r;
         y_r      <= y_r;
         colour_r <= colour_r;
      end
   end

   // Sticky overflow: a request was presented while the FIFO was full.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflow_r <= 1'b0;
      end else if (write_en && fifo_full_s) begin
         overflow_r <= 1'b1;
      end else begin
         overflow_r <= overflow_r;
      end
   end

   assign x        = x_r;
   assign y        = y_r;
   assign colour   = colour_r;
   assign plot     = (state_r == OUT_FULL);
   assign overflow = overflow_r;

`ifdef LASER_SINK_STATS_EN
   logic [15:0] plotted_cnt_r;
   logic [15:0] clipped_cnt_r;

   // Saturating counters of delivered and clipped pixels.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         plotted_cnt_r <= 16'd0;
         clipped_cnt_r <= 16'd0;
      end else begin
         if (plot && vga_ready) begin
            plotted_cnt_r <= sat_inc16(plotted_cnt_r);
         end
         if (accept_s && clipped_s) begin
            clipped_cnt_r <= sat_inc16(clipped_cnt_r);
         end
      end
   end

   assign plotted_cnt = plotted_cnt_r;
   assign clipped_cnt = clipped_cnt_r;
`endif

endmodule

// File: tb/tb_laser_pixel_sink.sv
module tb_laser_pixel_sink;
   import laser_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  base_x = 8'd0;
   logic [6:0]  base_y = 7'd0;
   logic [2:0]  add_x = 3'd0;
   logic [2:0]  colour_in = 3'd0;
   logic        write_en = 1'b0;
   logic        in_ready;
   logic [7:0]  x;
   logic [6:0]  y;
   logic [2:0]  colour;
   logic        plot;
   logic        vga_ready = 1'b0;
   logic        overflow;
`ifdef LASER_SINK_STATS_EN
   logic [15:0] plotted_cnt;
   logic [15:0] clipped_cnt;
`endif

   int          checks = 0;
   int          errors = 0;
   bit          mon_en = 1'b0;
   logic [17:0] exp_q[$];
   logic [2:0]  cols [6];

   laser_pixel_sink #(.DEPTH(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .base_x    (base_x),
      .base_y    (base_y),
      .add_x     (add_x),
      .colour_in (colour_in),
      .write_en  (write_en),
      .in_ready  (in_ready),
      .x         (x),
      .y         (y),
      .colour    (colour),
      .plot      (plot),
      .vga_ready (vga_ready),
      .overflow  (overflow)
`ifdef LASER_SINK_STATS_EN
      ,
      .plotted_cnt (plotted_cnt),
      .clipped_cnt (clipped_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Scoreboard: a pixel consumed at the coming edge must be the oldest expected one.
   always @(negedge clk) begin
      if (mon_en && !reset && plot && vga_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_extra: got x=%0d y=%0d colour=%b, expected no pixel", x, y, colour);
         end else begin
            logic [17:0] e;
            e = exp_q.pop_front();
            if ({x, y, colour} !== e) begin
               errors++;
               $display("FAIL sb_pixel: got x=%0d y=%0d colour=%b, expected x=%0d y=%0d colour=%b",
                        x, y, colour, e[17:10], e[9:3], e[2:0]);
            end
         end
      end
   end

   // Drive one request for one cycle; queue the expected pixel if it should be plotted.
   task automatic send(input logic [2:0] add, input logic [2:0] col, input bit acc);
      int ax;
      logic [7:0] ax8;
      ax = int'(base_x) + int'(add);
      ax8 = ax[7:0];
      write_en  = 1'b1;
      add_x     = add;
      colour_in = col;
      if (acc && ax < 160 && int'(base_y) < 120) exp_q.push_back({ax8, base_y, col});
      @(posedge clk); #1;
      write_en = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk); #2;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      exp_q.delete();
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && plot === 1'b0) break;
      end
      checks++;
      if (exp_q.size() != 0 || plot !== 1'b0) begin
         errors++;
         $display("FAIL %s_drain: %0d pixels still expected, plot=%b, required 0 and 0", name, exp_q.size(), plot);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({x, y, colour, plot, overflow, in_ready} !== {8'd0, 7'd0, 3'b000, 1'b0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL reset_state: got x=%0d y=%0d colour=%b plot=%b overflow=%b in_ready=%b, required 0 0 000 0 0 1",
                  x, y, colour, plot, overflow, in_ready);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      mon_en = 1'b1;
   endtask

   task automatic test_burst();
      logic plot_hist [9];
      base_x = 8'd10; base_y = 7'd20; vga_ready = 1'b1;
      for (int k = 0; k < 9; k++) begin
         if (k < 5) begin
            logic [7:0] ex;
            ex = 8'(10 + k);
            write_en = 1'b1; add_x = 3'(k); colour_in = cols[k];
            exp_q.push_back({ex, 7'd20, cols[k]});
         end else begin
            write_en = 1'b0;
         end
         @(negedge clk);
         plot_hist[k] = plot;
         @(posedge clk); #1;
      end
      write_en = 1'b0;
      for (int k = 0; k < 9; k++) begin
         logic expv;
         expv = (k >= 2 && k <= 6);
         checks++;
         if (plot_hist[k] !== expv) begin
            errors++;
            $display("FAIL burst_plot_timing: edge %0d plot=%b, required %b", k, plot_hist[k], expv);
         end
      end
      wait_drain("burst");
   endtask

   task automatic test_overflow();
      base_x = 8'd10; base_y = 7'd20; vga_ready = 1'b0;
      for (int i = 0; i < 6; i++) send(3'(i), cols[i], i < 5);
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || overflow !== 1'b1 || plot !== 1'b1 || x !== 8'd10) begin
         errors++;
         $display("FAIL overflow_full: in_ready=%b overflow=%b plot=%b x=%0d, required 0 1 1 10",
                  in_ready, overflow, plot, x);
      end
      @(posedge clk); #1;
      vga_ready = 1'b1;
      wait_drain("overflow");
      checks++;
      if (overflow !== 1'b1 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL overflow_sticky: overflow=%b in_ready=%b, required 1 1", overflow, in_ready);
      end
   endtask

   task automatic test_clip_x();
      do_reset();
      checks++;
      if (overflow !== 1'b0) begin
         errors++;
         $display("FAIL clipx_overflow_cleared: overflow=%b, required 0", overflow);
      end
      base_x = 8'd157; base_y = 7'd30; vga_ready = 1'b1;
      for (int i = 0; i < 5; i++) send(3'(i), 3'(i + 1), 1'b1);
      wait_drain("clipx");
      checks++;
      if (overflow !== 1'b0) begin
         errors++;
         $display("FAIL clipx_overflow: overflow=%b, required 0", overflow);
      end
`ifdef LASER_SINK_STATS_EN
      checks++;
      if (clipped_cnt !== 16'd2 || plotted_cnt !== 16'd3) begin
         errors++;
         $display("FAIL clipx_stats: clipped=%0d plotted=%0d, required 2 3", clipped_cnt, plotted_cnt);
      end
`endif
   endtask

   task automatic test_clip_y();
      base_x = 8'd5; base_y = 7'd120; vga_ready = 1'b1;
      for (int i = 0; i < 4; i++) send(3'(i), COL_RED, 1'b1);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checks++;
         if (plot !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL clipy_quiet: plot=%b in_ready=%b, required 0 1", plot, in_ready);
         end
      end
      @(posedge clk); #1;
`ifdef LASER_SINK_STATS_EN
      checks++;
      if (clipped_cnt !== 16'd6 || plotted_cnt !== 16'd3) begin
         errors++;
         $display("FAIL clipy_stats: clipped=%0d plotted=%0d, required 6 3", clipped_cnt, plotted_cnt);
      end
`endif
   endtask

   task automatic test_toggle();
      logic        tog;
      logic        hold_v;
      logic [17:0] held;
      base_x = 8'd30; base_y = 7'd40; vga_ready = 1'b0;
      for (int i = 0; i < 4; i++) send(3'(i * 2), 3'(7 - i), 1'b1);
      tog = 1'b1;
      for (int i = 0; i < 40; i++) begin
         vga_ready = tog;
         @(negedge clk);
         if (exp_q.size() == 0 && plot === 1'b0) break;
         hold_v = plot && !vga_ready;
         held = {x, y, colour};
         @(posedge clk); #1;
         if (hold_v) begin
            checks++;
            if ({x, y, colour} !== held || plot !== 1'b1) begin
               errors++;
               $display("FAIL toggle_hold: got x=%0d y=%0d colour=%b plot=%b, required x=%0d y=%0d colour=%b plot=1",
                        x, y, colour, plot, held[17:10], held[9:3], held[2:0]);
            end
         end
         tog = ~tog;
      end
      vga_ready = 1'b1;
      wait_drain("toggle");
   endtask

   task automatic test_reset_mid_drain();
      base_x = 8'd50; base_y = 7'd60; vga_ready = 1'b0;
      for (int i = 0; i < 4; i++) send(3'(i), COL_MAGENTA, 1'b1);
      @(negedge clk); #2;
      reset = 1'b1;
      #1;
      checks++;
      if (plot !== 1'b0 || in_ready !== 1'b1 || overflow !== 1'b0 || x !== 8'd0) begin
         errors++;
         $display("FAIL midreset_async: plot=%b in_ready=%b overflow=%b x=%0d, required 0 1 0 0",
                  plot, in_ready, overflow, x);
      end
      exp_q.delete();
      @(posedge clk); #1;
      reset = 1'b0;
      vga_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if (plot !== 1'b0) begin
            errors++;
            $display("FAIL midreset_no_plot: cycle %0d plot=%b, required 0", i, plot);
         end
      end
   endtask

   initial begin
      cols[0] = COL_RED;     cols[1] = COL_MAGENTA; cols[2] = COL_MAGENTA;
      cols[3] = COL_MAGENTA; cols[4] = COL_RED;     cols[5] = 3'b011;
      test_reset();
      test_burst();
      test_overflow();
      test_clip_x();
      test_clip_y();
      test_toggle();
      test_reset_mid_drain();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
